// File: rtl/bit_pack_pkg.sv
// Shared types and helpers for the bit field packer.
//   state_e    : packer FSM state (run / drain after a frame-closing field)
//   acc_width  : accumulator width, one full output word plus one widest field
//   lsb_mask   : mask with the low 'len' bits set (fields up to MASK_MAX_W bits)
package bit_pack_pkg;

    localparam int unsigned MASK_MAX_W = 64;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StDrain = 1'b1
    } state_e;

    function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned out_w);
        return in_w + out_w;
    endfunction

    function automatic logic [MASK_MAX_W-1:0] lsb_mask(input int unsigned len);
        logic [MASK_MAX_W-1:0] ones;
        ones = '1;
        if (len >= MASK_MAX_W) begin
            return ones;
        end
        return ~(ones << len);
    endfunction

endpackage

// File: rtl/field_mask.sv
// Clamps a field length to IN_W and clears all data bits above that length.
// Purely combinational.
//   data_i : raw field, right-aligned
//   len_i  : requested length, may exceed IN_W
//   data_o : field with bits at and above len_o forced to zero
//   len_o  : length clamped to IN_W
module field_mask
    import bit_pack_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned LEN_W = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]  data_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [IN_W-1:0]  data_o,
    output logic [LEN_W-1:0] len_o
);

    always_comb begin
        len_o  = (len_i > LEN_W'(IN_W)) ? LEN_W'(IN_W) : len_i;
        data_o = IN_W'(MASK_MAX_W'(data_i) & lsb_mask(32'(len_o)));
    end

endmodule

// File: rtl/bit_field_packer.sv
// Streaming bit field packer. Variable-length fields (0..IN_W LSBs of in_data_i)
// are concatenated MSB-first and emitted as OUT_W-bit words. A field flagged
// in_last_i closes the frame; the remainder goes out left-aligned and zero-padded
// with out_last_o set and out_bits_o giving the number of meaningful MSBs.
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   in_valid_i/in_ready_o              : field handshake
//   in_data_i, in_len_i, in_last_i     : field bits, length, end of frame
//   out_valid_o/out_ready_i            : word handshake
//   out_data_o, out_last_o, out_bits_o : word, end of frame, valid MSB count
module bit_field_packer
    import bit_pack_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned OUT_W  = 8,
    localparam int unsigned LEN_W  = $clog2(IN_W + 1),
    localparam int unsigned BITS_W = $clog2(OUT_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [IN_W-1:0]   in_data_i,
    input  logic [LEN_W-1:0]  in_len_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OUT_W-1:0]  out_data_o,
    output logic              out_last_o,
    output logic [BITS_W-1:0] out_bits_o
);

    localparam int unsigned ACC_W = acc_width(IN_W, OUT_W);
    localparam int unsigned CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] OutWCnt = CNT_W'(OUT_W);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [BITS_W-1:0]  out_bits_q, out_bits_d;

    logic [IN_W-1:0]    fld_data;
    logic [LEN_W-1:0]   fld_len;
    logic               accept;
    logic               slot_free;
    logic               word_avail;

    field_mask #(
        .IN_W  (IN_W),
        .LEN_W (LEN_W)
    ) u_field_mask (
        .data_i (in_data_i),
        .len_i  (in_len_i),
        .data_o (fld_data),
        .len_o  (fld_len)
    );

    // Intake stops once a full word is buffered, so accept and emit never coincide.
    assign in_ready_o = !rst_i && (state_q == StRun) && (cnt_q < OutWCnt);

    always_comb begin
        accept     = in_valid_i && in_ready_o;
        slot_free  = !out_valid_q || out_ready_i;
        word_avail = (state_q == StDrain) || (cnt_q >= OutWCnt);

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_bits_d  = out_bits_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            acc_d = (acc_q << fld_len) | ACC_W'(fld_data);
            cnt_d = cnt_q + CNT_W'(fld_len);
            if (in_last_i) begin
                state_d = StDrain;
            end
        end else if (slot_free && word_avail) begin
            out_valid_d = 1'b1;
            if ((state_q == StRun) || (cnt_q > OutWCnt)) begin
                // Oldest OUT_W buffered bits sit just below bit cnt_q.
                out_data_d = OUT_W'(acc_q >> (cnt_q - OutWCnt));
                out_last_d = 1'b0;
                out_bits_d = BITS_W'(OUT_W);
                cnt_d      = cnt_q - OutWCnt;
            end else begin
                // Tail of frame: left-align the last cnt_q bits, zero fill below.
                out_data_d = acc_q[OUT_W-1:0] << (OutWCnt - cnt_q);
                out_last_d = 1'b1;
                out_bits_d = BITS_W'(cnt_q);
                cnt_d      = '0;
                state_d    = StRun;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_bits_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_bits_q  <= out_bits_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_bits_o  = out_bits_q;

endmodule
